uart_tx_arbiter: RTL

Round-robin arbiter that shares a single UART transmitter among `N_REQ` byte-producing clients. It sits between the clients and the transmitter: it grants one client at a time, presents that client's byte on the transmitter's parallel input, and drives `load`. It then tracks the transmitter's `tx_status` through the full frame before granting again. Everything runs in the baud clock domain.

---
 rtl/uart_pkg.sv | 13 +
 rtl/uart_tx_arbiter_rr_pick.sv | 25 ++
 rtl/uart_tx_arbiter.sv | 111 +++++++++++
 3 files changed

// File: rtl/uart_pkg.sv
// uart_pkg: shared types and constants for the UART transmit-side blocks
package uart_pkg;

    localparam int UART_DATA_W       = 8;
    localparam int LOAD_TIMEOUT_DFLT = 8;

    typedef enum logic [1:0] {
        IDLE,
        LOAD,
        WAIT_DONE
    } arb_state_t;

endpackage

// File: rtl/uart_tx_arbiter_rr_pick.sv
// rr_pick: combinational round-robin selector, first set request after cur_idx
module rr_pick #(
    parameter int N  = 4,
    parameter int IW = $clog2(N)
) (
    input  logic [N-1:0]  req,
    input  logic [IW-1:0] cur_idx,
    output logic          valid,
    output logic [IW-1:0] idx
);

    logic [IW-1:0] cand;

    // Scan from the farthest candidate back to the nearest so the nearest set request wins
    always_comb begin
        valid = |req;
        idx   = cur_idx;
        cand  = '0;
        for (int k = N; k >= 1; k--) begin
            cand = IW'((int'(cur_idx) + k) % N);
            if (req[cand]) idx = cand;
        end
    end

endmodule

// File: rtl/uart_tx_arbiter.sv
// uart_tx_arbiter: round-robin sharing of one UART transmitter; optional load timeout via UART_TX_ARB_TIMEOUT_EN
module uart_tx_arbiter
    import uart_pkg::*;
#(
    parameter int N_REQ        = 4,
    parameter int IDX_W        = $clog2(N_REQ),
    parameter int LOAD_TIMEOUT = LOAD_TIMEOUT_DFLT
) (
    input  logic                           bclk,
    input  logic                           reset,
    input  logic [N_REQ-1:0]               req,
    input  logic [N_REQ*UART_DATA_W-1:0]   req_data,
    output logic [N_REQ-1:0]               gnt,
    input  logic                           tx_status,
    output logic                           tx_load,
    output logic [UART_DATA_W-1:0]         tx_data,
    output logic                           busy,
    output logic [IDX_W-1:0]               cur_idx,
    output logic                           err
);

    if (N_REQ < 2 || N_REQ > 8 || LOAD_TIMEOUT < 1) begin : g_bad_cfg
        $error("uart_tx_arbiter: unsupported N_REQ or LOAD_TIMEOUT");
    end

    arb_state_t             state_q;
    logic [N_REQ-1:0]       gnt_q;
    logic                   load_q;
    logic [UART_DATA_W-1:0] data_q;
    logic [IDX_W-1:0]       idx_q;
    logic                   pick_valid;
    logic [IDX_W-1:0]       pick_idx;

`ifdef UART_TX_ARB_TIMEOUT_EN
    localparam int CNT_W = $clog2(LOAD_TIMEOUT + 1);
    logic [CNT_W-1:0] cnt_q;
    logic             err_q;
`endif

    rr_pick #(.N(N_REQ), .IW(IDX_W)) u_pick (
        .req     (req),
        .cur_idx (idx_q),
        .valid   (pick_valid),
        .idx     (pick_idx)
    );

    // Grant, hold load until the transmitter goes busy, then wait for the frame to finish
    always_ff @(posedge bclk or posedge reset) begin
        if (reset) begin
            state_q <= IDLE;
            gnt_q   <= '0;
            load_q  <= 1'b0;
            data_q  <= '0;
            idx_q   <= IDX_W'(N_REQ - 1);
`ifdef UART_TX_ARB_TIMEOUT_EN
            cnt_q   <= '0;
            err_q   <= 1'b0;
`endif
        end else begin
            gnt_q <= '0;
`ifdef UART_TX_ARB_TIMEOUT_EN
            err_q <= 1'b0;
`endif
            case (state_q)
                IDLE: begin
                    if (pick_valid && tx_status) begin
                        gnt_q   <= N_REQ'(1) << pick_idx;
                        data_q  <= req_data[pick_idx*UART_DATA_W +: UART_DATA_W];
                        idx_q   <= pick_idx;
                        load_q  <= 1'b1;
                        state_q <= LOAD;
`ifdef UART_TX_ARB_TIMEOUT_EN
                        cnt_q   <= '0;
`endif
                    end
                end
                LOAD: begin
                    if (!tx_status) begin
                        load_q  <= 1'b0;
                        state_q <= WAIT_DONE;
                    end
`ifdef UART_TX_ARB_TIMEOUT_EN
                    else if (cnt_q == CNT_W'(LOAD_TIMEOUT - 1)) begin
                        load_q  <= 1'b0;
                        err_q   <= 1'b1;
                        state_q <= IDLE;
                    end else begin
                        cnt_q <= cnt_q + 1'b1;
                    end
`endif
                end
                WAIT_DONE: begin
                    if (tx_status) state_q <= IDLE;
                end
                default: state_q <= IDLE;
            endcase
        end
    end

    assign gnt     = gnt_q;
    assign tx_load = load_q;
    assign tx_data = data_q;
    assign cur_idx = idx_q;
    assign busy    = (state_q != IDLE);
`ifdef UART_TX_ARB_TIMEOUT_EN
    assign err     = err_q;
`else
    assign err     = 1'b0;
`endif

endmodule
